// File: rtl/synth_ctrl_pkg.sv
// Shared MIDI controller constants, decoded command flags and the slew step helper.
package synth_ctrl_pkg;

   localparam logic [13:0] PB_CENTER    = 14'd8192;
   localparam logic [6:0]  CC_MOD_MSB   = 7'd1;
   localparam logic [6:0]  CC_MOD_LSB   = 7'd33;
   localparam logic [6:0]  CC_RESET_ALL = 7'd121;

   typedef struct packed {
      logic pitch_wr;
      logic mod_msb;
      logic mod_lsb;
      logic reset_all;
   } ctrl_cmd_t;

   // Move cur toward tgt by at most step; lands exactly on tgt instead of overshooting.
   function automatic logic [13:0] slew_next(input logic [13:0] cur,
                                             input logic [13:0] tgt,
                                             input logic [13:0] step);
      logic [13:0] diff;
      if (tgt >= cur) begin
         diff      = tgt - cur;
         slew_next = (diff > step) ? cur + step : tgt;
      end else begin
         diff      = cur - tgt;
         slew_next = (diff > step) ? cur - step : tgt;
      end
   endfunction

endpackage

// File: rtl/rt_slew.sv
// One channel of pitch smoothing: steps the output toward the target once per tick.
module rt_slew
   import synth_ctrl_pkg::*;
#(
   parameter int unsigned SLEW_STEP = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [13:0] target_i,
   input  logic        tick_i,
   output logic [13:0] smooth_o
);

   localparam logic [13:0] STEP = 14'(SLEW_STEP);

   logic [13:0] smooth_q, smooth_d;

   generate
      if (SLEW_STEP == 0) begin : g_bypass
         assign smooth_d = target_i;
      end else begin : g_slew
         assign smooth_d = tick_i ? slew_next(smooth_q, target_i, STEP) : smooth_q;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) smooth_q <= PB_CENTER;
      else         smooth_q <= smooth_d;
   end

   assign smooth_o = smooth_q;

endmodule

// File: rtl/rt_controllers_mc.sv
// Multi-channel MIDI pitch-bend / mod-wheel tracker with per-channel slewed pitch output.
module rt_controllers_mc
   import synth_ctrl_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int CH_WIDTH  = 1,
   parameter int SLEW_DIV  = 50,
   parameter int SLEW_STEP = 64
) (
   input  logic                     CLOCK_50,
   input  logic                     reset_data_N,
   input  logic [7:0]               ictrl,
   input  logic [7:0]               ictrl_data,
   input  logic [CH_WIDTH-1:0]      ch,
   input  logic                     pitch_cmd,
   input  logic                     cc_cmd,
   output logic [CHANNELS*14-1:0]   pitch_val,
   output logic [CHANNELS*14-1:0]   pitch_smooth,
   output logic [CHANNELS*14-1:0]   mod_val,
   output logic [CHANNELS-1:0]      pitch_upd
);

   localparam int            CW       = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(SLEW_DIV - 1);

   logic                      pitch_cmd_q, cc_cmd_q;
   logic                      pitch_rise, cc_rise, ch_ok;
   logic [31:0]               ch_idx;
   logic [6:0]                ctrl_num;
   ctrl_cmd_t                 cmd;
   logic [CW-1:0]             tick_cnt_q, tick_cnt_d;
   logic                      tick;
   logic [CHANNELS-1:0][13:0] pitch_val_q, pitch_val_d;
   logic [CHANNELS-1:0][13:0] mod_val_q, mod_val_d;
   logic [CHANNELS-1:0][13:0] smooth_w;
   logic [CHANNELS-1:0]       pitch_upd_q, pitch_upd_d;
   logic                      unused_bit7;

   // MIDI data bytes are 7-bit; the top bit carries nothing.
   assign unused_bit7 = ^{ictrl[7], ictrl_data[7]};

   assign pitch_rise = pitch_cmd & ~pitch_cmd_q;
   assign cc_rise    = cc_cmd & ~cc_cmd_q;
   assign ch_idx     = 32'(ch);
   assign ch_ok      = ch_idx < 32'(CHANNELS);
   assign ctrl_num   = ictrl[6:0];

   always_comb begin
      cmd           = '0;
      cmd.pitch_wr  = pitch_rise;
      cmd.mod_msb   = cc_rise && (ctrl_num == CC_MOD_MSB);
      cmd.mod_lsb   = cc_rise && (ctrl_num == CC_MOD_LSB);
      cmd.reset_all = cc_rise && (ctrl_num == CC_RESET_ALL);
   end

   // Reset-all is applied last so it overrides a coincident pitch write.
   always_comb begin
      pitch_val_d = pitch_val_q;
      mod_val_d   = mod_val_q;
      pitch_upd_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ch_ok && (ch_idx == 32'(k))) begin
            if (cmd.pitch_wr) pitch_val_d[k]     = {ictrl_data[6:0], ictrl[6:0]};
            if (cmd.mod_msb)  mod_val_d[k]       = {ictrl_data[6:0], 7'd0};
            if (cmd.mod_lsb)  mod_val_d[k][6:0]  = ictrl_data[6:0];
            if (cmd.reset_all) begin
               pitch_val_d[k] = PB_CENTER;
               mod_val_d[k]   = '0;
            end
            pitch_upd_d[k] = cmd.pitch_wr | cmd.reset_all;
         end
      end
   end

   assign tick       = (tick_cnt_q == DIV_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   always_ff @(posedge CLOCK_50 or negedge reset_data_N) begin
      if (!reset_data_N) begin
         pitch_cmd_q <= 1'b0;
         cc_cmd_q    <= 1'b0;
         tick_cnt_q  <= '0;
         pitch_val_q <= {CHANNELS{PB_CENTER}};
         mod_val_q   <= '0;
         pitch_upd_q <= '0;
      end else begin
         pitch_cmd_q <= pitch_cmd;
         cc_cmd_q    <= cc_cmd;
         tick_cnt_q  <= tick_cnt_d;
         pitch_val_q <= pitch_val_d;
         mod_val_q   <= mod_val_d;
         pitch_upd_q <= pitch_upd_d;
      end
   end

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
         rt_slew #(
            .SLEW_STEP (SLEW_STEP)
         ) u_slew (
            .clk_i    (CLOCK_50),
            .rst_ni   (reset_data_N),
            .target_i (pitch_val_q[g]),
            .tick_i   (tick),
            .smooth_o (smooth_w[g])
         );
      end
   endgenerate

   assign pitch_val    = pitch_val_q;
   assign pitch_smooth = smooth_w;
   assign mod_val      = mod_val_q;
   assign pitch_upd    = pitch_upd_q;

endmodule
